// File: rtl/dbf_pkg.sv
// dbf_pkg: definitions shared by the DBF scan controller and the channel blocks.
//   - ADDR_WD_DEF / APO_WD_DEF : default LUT-address and apodization widths
//   - scan_state_t             : per-scan sequencer states
package dbf_pkg;

    localparam int ADDR_WD_DEF = 10;
    localparam int APO_WD_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_SETTLE,
        ST_RX,
        ST_GAP
    } scan_state_t;

endpackage

// File: rtl/dbf_apo_ram.sv
// dbf_apo_ram: apodization coefficient table, one write port, one read port.
// Ports:
//   clk      in  - clock
//   wr_en    in  - write strobe
//   wr_addr  in  - write address (focal zone)
//   wr_data  in  - signed coefficient to store
//   rd_clr   in  - forces the read register to zero instead of reading
//   rd_addr  in  - read address, registered read
//   rd_data  out - signed coefficient, one cycle after rd_addr
// A read and a write to the same address in the same cycle return the old
// contents. The array itself is never cleared; the read register is zeroed
// through rd_clr, which the controller also raises during reset.
module dbf_apo_ram
    import dbf_pkg::*;
#(
    parameter int ADDR_WD = ADDR_WD_DEF,
    parameter int APO_WD  = APO_WD_DEF
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [ADDR_WD-1:0]        wr_addr,
    input  logic signed [APO_WD-1:0]  wr_data,
    input  logic                      rd_clr,
    input  logic [ADDR_WD-1:0]        rd_addr,
    output logic signed [APO_WD-1:0]  rd_data
);

    logic signed [APO_WD-1:0] mem [2**ADDR_WD];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_clr) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/dbf_scan_ctrl.sv
// dbf_scan_ctrl: per-scan sequencer for the DBF receive channel array.
// Sequence per line: TX (tx_en) -> SETTLE -> RX (start, LUT address/strobe,
// apodization) -> GAP, repeated for NUM_LINES lines.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   scan_go             - frame start pulse, only honoured in IDLE
//   scan_abort          - return to IDLE from any state, beats scan_go
//   apo_wr_en/addr/data - host write port of the apodization table
//   tx_en               - transmit burst active
//   start               - receive window active
//   dbf_lut_addr        - focal-zone address (saturating), 0 outside RX
//   dbf_lut_we          - strobe on each zone entry below saturation
//   apo_din             - coefficient of the current zone, 0 outside RX
//   line_idx            - current line within the frame
//   line_done           - pulse on the last RX sample of each line
//   scan_busy           - high in every state but IDLE
//   scan_done           - pulse on the last GAP cycle of the last line
// Every output is a flop loaded from the next-state decode, so outputs line
// up with the state they describe and no input reaches an output directly.
module dbf_scan_ctrl
    import dbf_pkg::*;
#(
    parameter int ADDR_WD       = ADDR_WD_DEF,
    parameter int APO_WD        = APO_WD_DEF,
    parameter int LINE_LEN      = 1024,
    parameter int ZONE_SHIFT    = 2,
    parameter int TX_CYCLES     = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int GAP_CYCLES    = 16,
    parameter int NUM_LINES     = 128,
    localparam int LINE_W       = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      scan_go,
    input  logic                      scan_abort,
    input  logic                      apo_wr_en,
    input  logic [ADDR_WD-1:0]        apo_wr_addr,
    input  logic signed [APO_WD-1:0]  apo_wr_data,
    output logic                      tx_en,
    output logic                      start,
    output logic [ADDR_WD-1:0]        dbf_lut_addr,
    output logic                      dbf_lut_we,
    output logic signed [APO_WD-1:0]  apo_din,
    output logic [LINE_W-1:0]         line_idx,
    output logic                      line_done,
    output logic                      scan_busy,
    output logic                      scan_done
);

    // One counter serves every timed state; in RX it is the sample index s.
    localparam int MAX_TS  = (TX_CYCLES > SETTLE_CYCLES) ? TX_CYCLES : SETTLE_CYCLES;
    localparam int MAX_LG  = (LINE_LEN > GAP_CYCLES) ? LINE_LEN : GAP_CYCLES;
    localparam int MAX_CNT = (MAX_TS > MAX_LG) ? MAX_TS : MAX_LG;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0]  TX_LAST     = CNT_W'(TX_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RX_LAST     = CNT_W'(LINE_LEN - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [LINE_W-1:0] LINE_LAST   = LINE_W'(NUM_LINES - 1);
    localparam logic [31:0]       ZONE_MAX    = 32'((2 ** ADDR_WD) - 1);
    localparam logic [31:0]       ZONE_MASK   = 32'((2 ** ZONE_SHIFT) - 1);

    // Unsaturated focal zone of sample s, kept wide so the saturation
    // compare works for any LINE_LEN / ADDR_WD combination.
    function automatic logic [31:0] zone_of(input logic [CNT_W-1:0] s);
        return 32'(s) >> ZONE_SHIFT;
    endfunction

    function automatic logic [ADDR_WD-1:0] sat_zone(input logic [31:0] z);
        if (z > ZONE_MAX) begin
            return ADDR_WD'(ZONE_MAX);
        end
        return ADDR_WD'(z);
    endfunction

    scan_state_t         state;
    scan_state_t         state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [LINE_W-1:0]   line_nxt;
    logic [31:0]         zone_nxt;
    logic [ADDR_WD-1:0]  addr_nxt;
    logic                rx_nxt;
    logic                we_nxt;
    logic                line_done_nxt;
    logic                scan_done_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        line_nxt  = line_idx;

        case (state)
            ST_IDLE: begin
                cnt_nxt  = '0;
                line_nxt = '0;
                if (scan_go) begin
                    state_nxt = ST_TX;
                end
            end
            ST_TX: begin
                if (cnt == TX_LAST) begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_nxt = ST_RX;
                    cnt_nxt   = '0;
                end
            end
            ST_RX: begin
                if (cnt == RX_LAST) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = '0;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt = '0;
                    if (line_idx == LINE_LAST) begin
                        state_nxt = ST_IDLE;
                        line_nxt  = '0;
                    end else begin
                        state_nxt = ST_TX;
                        line_nxt  = line_idx + LINE_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                line_nxt  = '0;
            end
        endcase

        // Abort overrides everything, including a simultaneous scan_go.
        if (scan_abort) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            line_nxt  = '0;
        end

        rx_nxt        = (state_nxt == ST_RX);
        zone_nxt      = zone_of(cnt_nxt);
        addr_nxt      = rx_nxt ? sat_zone(zone_nxt) : '0;
        we_nxt        = rx_nxt && ((32'(cnt_nxt) & ZONE_MASK) == 32'd0)
                        && (zone_nxt <= ZONE_MAX);
        line_done_nxt = rx_nxt && (cnt_nxt == RX_LAST);
        scan_done_nxt = (state_nxt == ST_GAP) && (cnt_nxt == GAP_LAST)
                        && (line_nxt == LINE_LAST);
    end

    // ---- state / output register stage ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            line_idx     <= '0;
            tx_en        <= 1'b0;
            start        <= 1'b0;
            dbf_lut_addr <= '0;
            dbf_lut_we   <= 1'b0;
            line_done    <= 1'b0;
            scan_busy    <= 1'b0;
            scan_done    <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            line_idx     <= line_nxt;
            tx_en        <= (state_nxt == ST_TX);
            start        <= rx_nxt;
            dbf_lut_addr <= addr_nxt;
            dbf_lut_we   <= we_nxt;
            line_done    <= line_done_nxt;
            scan_busy    <= (state_nxt != ST_IDLE);
            scan_done    <= scan_done_nxt;
        end
    end

    // The table is read with next cycle's address so apo_din lands in the
    // same cycle as dbf_lut_addr; rd_clr zeroes it outside RX and in reset.
    dbf_apo_ram #(
        .ADDR_WD (ADDR_WD),
        .APO_WD  (APO_WD)
    ) u_apo_ram (
        .clk     (clk),
        .wr_en   (apo_wr_en),
        .wr_addr (apo_wr_addr),
        .wr_data (apo_wr_data),
        .rd_clr  (rst || !rx_nxt),
        .rd_addr (addr_nxt),
        .rd_data (apo_din)
    );

endmodule

// File: tb/tb_dbf_scan_ctrl.sv
// Directed bench for dbf_scan_ctrl. u_dut uses default timing with
// NUM_LINES=2; u_dut2 uses ZONE_SHIFT=0, LINE_LEN=2048, NUM_LINES=1 to reach
// address saturation. Expected values come from the timing arithmetic below.
module tb_dbf_scan_ctrl;

    localparam int AW  = 10;
    localparam int DW  = 16;
    localparam int TXC = 8;
    localparam int STC = 4;
    localparam int GPC = 16;
    localparam int LL1 = 1024;
    localparam int LL2 = 2048;
    localparam int RX0 = TXC + STC;
    localparam int LP1 = TXC + STC + LL1 + GPC;
    localparam int LP2 = TXC + STC + LL2 + GPC;
    localparam int INJ_NONE  = 0;
    localparam int INJ_GO    = 1;
    localparam int INJ_ABORT = 2;
    localparam int INJ_RST   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scan_go = 1'b0;
    logic scan_go2 = 1'b0;
    logic scan_abort = 1'b0;
    logic apo_wr_en = 1'b0;
    logic [AW-1:0] apo_wr_addr = '0;
    logic signed [DW-1:0] apo_wr_data = '0;

    logic tx_en, start, lut_we, line_done, scan_busy, scan_done;
    logic [AW-1:0] lut_addr;
    logic signed [DW-1:0] apo_din;
    logic [0:0] line_idx;

    logic tx_en2, start2, lut_we2, line_done2, scan_busy2, scan_done2;
    logic [AW-1:0] lut_addr2;
    logic signed [DW-1:0] apo_din2;
    logic [0:0] line_idx2;

    int checks = 0;
    int errors = 0;
    int mm_tx, mm_start, mm_addr, mm_we, mm_ld, mm_apo, mm_busy, mm_line, mm_done;
    int n_tx, n_start, n_we, n_ld, n_done;

    always #5 clk = ~clk;

    dbf_scan_ctrl #(
        .NUM_LINES (2)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .scan_go      (scan_go),
        .scan_abort   (scan_abort),
        .apo_wr_en    (apo_wr_en),
        .apo_wr_addr  (apo_wr_addr),
        .apo_wr_data  (apo_wr_data),
        .tx_en        (tx_en),
        .start        (start),
        .dbf_lut_addr (lut_addr),
        .dbf_lut_we   (lut_we),
        .apo_din      (apo_din),
        .line_idx     (line_idx),
        .line_done    (line_done),
        .scan_busy    (scan_busy),
        .scan_done    (scan_done)
    );

    dbf_scan_ctrl #(
        .LINE_LEN   (LL2),
        .ZONE_SHIFT (0),
        .NUM_LINES  (1)
    ) u_dut2 (
        .clk          (clk),
        .rst          (rst),
        .scan_go      (scan_go2),
        .scan_abort   (scan_abort),
        .apo_wr_en    (apo_wr_en),
        .apo_wr_addr  (apo_wr_addr),
        .apo_wr_data  (apo_wr_data),
        .tx_en        (tx_en2),
        .start        (start2),
        .dbf_lut_addr (lut_addr2),
        .dbf_lut_we   (lut_we2),
        .apo_din      (apo_din2),
        .line_idx     (line_idx2),
        .line_done    (line_done2),
        .scan_busy    (scan_busy2),
        .scan_done    (scan_done2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle1(input string tag);
        chk(tag, 64'({tx_en, start, lut_addr, lut_we, line_done, apo_din,
                      scan_busy, line_idx, scan_done}), 64'd0);
    endtask

    task automatic chk_idle2(input string tag);
        chk(tag, 64'({tx_en2, start2, lut_addr2, lut_we2, line_done2, apo_din2,
                      scan_busy2, line_idx2, scan_done2}), 64'd0);
    endtask

    task automatic idle_watch(input int n, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if ({tx_en, start, lut_addr, lut_we, line_done, apo_din,
                 scan_busy, line_idx, scan_done} !== '0) bad++;
        end
        chk(tag, 64'(bad), 64'd0);
    endtask

    // Walks np cycles of one line starting at phase p=0 (first TX cycle),
    // tallying per-signal mismatches against the timing model. At phase
    // inj_p the chosen input is raised for exactly one clock edge.
    task automatic step_line(input bit d2, input int line, input int np,
                             input bit last, input int inj_p, input int inj_kind);
        int ll, zs, lp, s, z, e_addr, e_apo;
        bit e_tx, e_st, e_we, e_ld, e_done;
        logic o_tx, o_st, o_we, o_ld, o_busy, o_done;
        logic [0:0] o_line;
        logic [AW-1:0] o_addr;
        logic signed [DW-1:0] o_apo;
        ll = d2 ? LL2 : LL1;
        zs = d2 ? 0 : 2;
        lp = RX0 + ll + GPC;
        mm_tx = 0; mm_start = 0; mm_addr = 0; mm_we = 0; mm_ld = 0;
        mm_apo = 0; mm_busy = 0; mm_line = 0; mm_done = 0;
        n_tx = 0; n_start = 0; n_we = 0; n_ld = 0; n_done = 0;
        for (int p = 0; p < np; p++) begin
            if (d2) begin
                o_tx = tx_en2; o_st = start2; o_we = lut_we2; o_ld = line_done2;
                o_busy = scan_busy2; o_done = scan_done2; o_line = line_idx2;
                o_addr = lut_addr2; o_apo = apo_din2;
            end else begin
                o_tx = tx_en; o_st = start; o_we = lut_we; o_ld = line_done;
                o_busy = scan_busy; o_done = scan_done; o_line = line_idx;
                o_addr = lut_addr; o_apo = apo_din;
            end
            e_tx   = (p < TXC);
            e_st   = (p >= RX0) && (p < RX0 + ll);
            s      = p - RX0;
            z      = e_st ? (s >> zs) : 0;
            e_addr = e_st ? ((z > 1023) ? 1023 : z) : 0;
            e_we   = e_st && ((s % (1 << zs)) == 0) && (z <= 1023);
            e_ld   = e_st && (s == ll - 1);
            e_apo  = e_st ? 100 + e_addr : 0;
            e_done = last && (p == lp - 1);
            if (o_tx !== e_tx) mm_tx++;
            if (o_st !== e_st) mm_start++;
            if (o_addr !== AW'(e_addr)) mm_addr++;
            if (o_we !== e_we) mm_we++;
            if (o_ld !== e_ld) mm_ld++;
            if (o_apo !== DW'(e_apo)) mm_apo++;
            if (o_busy !== 1'b1) mm_busy++;
            if (o_line !== 1'(line)) mm_line++;
            if (o_done !== e_done) mm_done++;
            if (o_tx === 1'b1) n_tx++;
            if (o_st === 1'b1) n_start++;
            if (o_we === 1'b1) n_we++;
            if (o_ld === 1'b1) n_ld++;
            if (o_done === 1'b1) n_done++;
            if (p == inj_p) begin
                case (inj_kind)
                    INJ_GO:    scan_go = 1'b1;
                    INJ_ABORT: scan_abort = 1'b1;
                    INJ_RST:   rst = 1'b1;
                    default:   ;
                endcase
            end
            tick();
            scan_go = 1'b0;
            scan_abort = 1'b0;
            rst = 1'b0;
        end
    endtask

    task automatic report_line(input string tag);
        chk({tag, " tx_en"}, 64'(mm_tx), 64'd0);
        chk({tag, " start"}, 64'(mm_start), 64'd0);
        chk({tag, " lut_addr"}, 64'(mm_addr), 64'd0);
        chk({tag, " lut_we"}, 64'(mm_we), 64'd0);
        chk({tag, " line_done"}, 64'(mm_ld), 64'd0);
        chk({tag, " apo_din"}, 64'(mm_apo), 64'd0);
        chk({tag, " scan_busy"}, 64'(mm_busy), 64'd0);
        chk({tag, " line_idx"}, 64'(mm_line), 64'd0);
        chk({tag, " scan_done"}, 64'(mm_done), 64'd0);
    endtask

    task automatic report_counts(input string tag, input int etx, input int est,
                                 input int ewe, input int eld, input int edone);
        chk({tag, " tx count"}, 64'(n_tx), 64'(etx));
        chk({tag, " start count"}, 64'(n_start), 64'(est));
        chk({tag, " we count"}, 64'(n_we), 64'(ewe));
        chk({tag, " line_done count"}, 64'(n_ld), 64'(eld));
        chk({tag, " scan_done count"}, 64'(n_done), 64'(edone));
    endtask

    task automatic go1;
        scan_go = 1'b1;
        tick();
        scan_go = 1'b0;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk_idle1("reset dut1");
        chk_idle2("reset dut2");

        // Preload coefficient = 100 + addr
        for (int a = 0; a < 1024; a++) begin
            apo_wr_en = 1'b1;
            apo_wr_addr = AW'(a);
            apo_wr_data = DW'(100 + a);
            tick();
        end
        apo_wr_en = 1'b0;
        chk_idle1("idle after preload");

        // scan_go together with scan_abort in IDLE: no start
        scan_go = 1'b1;
        scan_abort = 1'b1;
        tick();
        scan_go = 1'b0;
        scan_abort = 1'b0;
        chk_idle1("go+abort in idle");
        idle_watch(20, "go+abort stays idle");

        // Frame A: two full lines, scan_go repeated during TX is ignored
        go1();
        step_line(1'b0, 0, LP1, 1'b0, 3, INJ_GO);
        report_line("A line0");
        report_counts("A line0", 8, 1024, 256, 1, 0);
        step_line(1'b0, 1, LP1, 1'b1, -1, INJ_NONE);
        report_line("A line1");
        report_counts("A line1", 8, 1024, 256, 1, 1);
        chk_idle1("A end of frame");

        // Frame B: abort at RX sample 300 of line 1
        go1();
        step_line(1'b0, 0, LP1, 1'b0, -1, INJ_NONE);
        report_line("B line0");
        step_line(1'b0, 1, RX0 + 301, 1'b0, RX0 + 300, INJ_ABORT);
        report_line("B line1 to abort");
        chk_idle1("B abort clears outputs");
        idle_watch(40, "B no scan_done after abort");

        // Frame C: restart from line 0, reset in GAP of line 0
        go1();
        step_line(1'b0, 0, RX0 + LL1 + 6, 1'b0, RX0 + LL1 + 5, INJ_RST);
        report_line("C line0 to reset");
        chk_idle1("C reset in GAP");
        idle_watch(5, "C idle after reset");

        // Frame D: full frame again, table must be intact
        go1();
        step_line(1'b0, 0, LP1, 1'b0, -1, INJ_NONE);
        report_line("D line0");
        report_counts("D line0", 8, 1024, 256, 1, 0);
        step_line(1'b0, 1, LP1, 1'b1, -1, INJ_NONE);
        report_line("D line1");
        report_counts("D line1", 8, 1024, 256, 1, 1);
        chk_idle1("D end of frame");

        // Saturation: ZONE_SHIFT=0, LINE_LEN=2048
        scan_go2 = 1'b1;
        tick();
        scan_go2 = 1'b0;
        step_line(1'b1, 0, LP2, 1'b1, -1, INJ_NONE);
        report_line("SAT line0");
        report_counts("SAT line0", 8, 2048, 1024, 1, 1);
        chk_idle2("SAT end of frame");
        chk_idle1("dut1 idle during SAT");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
